vcxo_loop_filter: RTL
=====================

VCXO_LOOP_FILTER -- requirements
Module: vcxo_loop_filter

Interface
REQ-001 SHALL have parameter KI, default 1, integrator step per cycle of one-sided PFD activity.
REQ-002 SHALL have parameter KP, default 256, proportional offset applied to tune while a PFD output is active.
REQ-003 SHALL have parameter WIN, default 48000, lock-detect window length in clocks (1 ms at 48 MHz).
REQ-004 SHALL have parameter LOCK_THR, default 48, max active cycles per window counted as "good".
REQ-005 SHALL have parameter UNLOCK_THR, default 480, active cycles per window that force loss of lock.
REQ-006 SHALL have parameter LOCK_CNT, default 8, consecutive good windows required to declare lock.
REQ-007 SHALL have port ref_in, input, 1, 48 MHz reference clock; the only clock, all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-009 SHALL have port enable, input, 1, loop run; low freezes the loop.
REQ-010 SHALL have port up, input, 1, PFD "osc lags" pulse, asynchronous to ref_in.
REQ-011 SHALL have port down, input, 1, PFD "osc leads" pulse, asynchronous to ref_in.
REQ-012 SHALL have port tune, output, 16, VCXO control word, unsigned, 0x8000 = midscale.
REQ-013 SHALL have port pwm_out, output, 1, PWM DAC drive of tune, for an RC filter to the VCXO.
REQ-014 SHALL have port locked, output, 1, loop lock indication.
REQ-015 SHALL have port saturated, output, 1, integrator at a rail.

Function
REQ-016 SHALL pass up and down each through a two-flop synchronizer; up_s/down_s are the second-stage outputs.
REQ-017 SHALL keep a 24-bit unsigned integrator acc: up_s&!down_s -> acc+KI; down_s&!up_s -> acc-KI; both or neither -> hold.
REQ-018 SHALL clamp acc at 0x000000 and 0xFFFFFF with no wrap-around; saturated=1 whenever acc is at either rail.
REQ-019 SHALL register tune = acc[23:8] +KP if up_s only, -KP if down_s only, +0 otherwise, clamped to 0x0000..0xFFFF.
REQ-020 SHALL give latency: an up edge on the pin changes acc at the 3rd rising ref_in edge and tune at the 4th.
REQ-021 SHALL run a free-running 16-bit pwm_cnt that wraps 0xFFFF->0x0000.
REQ-022 SHALL load a shadow duty register from tune only when pwm_cnt==0xFFFF, so duty never changes mid-period.
REQ-023 SHALL register pwm_out = (pwm_cnt < duty); duty 0 gives constant 0, duty 0xFFFF gives 0 for exactly 1 cycle per period.
REQ-024 SHALL count active cycles (up_s|down_s) in a window counter running 0..WIN-1; evaluation at WIN-1, then both counters restart.
REQ-025 SHALL implement a lock FSM with states IDLE, ACQUIRE, LOCKED.
REQ-026 SHALL go IDLE->ACQUIRE when enable=1, clearing the window, active and good-window counters.
REQ-027 SHALL, in ACQUIRE, increment the good-window count when a window ends with active<=LOCK_THR, clear it otherwise, and go to LOCKED when it reaches LOCK_CNT.
REQ-028 SHALL go LOCKED->ACQUIRE at the first window ending with active>=UNLOCK_THR; windows between the thresholds keep LOCKED.
REQ-029 SHALL go to IDLE from any state on enable=0, within one cycle.
REQ-030 SHALL, in IDLE, hold acc and tune, ignore up/down, and keep PWM running.
REQ-031 SHALL drive locked=1 only in LOCKED.

Reset
REQ-032 SHALL, at a rising edge with rst_n=0, set synchronizers=0, acc=0x800000, tune=0x8000, duty=0x8000, pwm_cnt=0, pwm_out=0, window and active counters=0, state=IDLE, locked=0, saturated=0.
REQ-033 SHALL let reset override all other activity, including mid-window and mid-PWM-period; no output holds a pre-reset value after that edge.

Verification
REQ-034 Reset then enable=1, up held high 10 cycles -> acc=0x80000A after the pulse, tune=0x8100 during the pulse, tune=0x8000 after.
REQ-035 up and down both high 100 cycles -> acc and tune unchanged, at 0x800000 and 0x8000.
REQ-036 Reset, KI=0x10000, down held high -> acc clamps at 0x000000, saturated=1, tune=0x0000, no wrap.
REQ-037 Reset, enable=1, 1 kHz up pulses of 20 ns -> locked=1 at end of 8th window; widen pulses to 12 us -> locked=0 at the next window end.
REQ-038 tune changes from 0x4000 to 0xC000 mid-period -> pwm_out keeps 16384 high cycles that period, then 49152 the next.
REQ-039 rst_n=0 for one cycle while LOCKED mid-window -> next cycle state=IDLE, locked=0, acc=0x800000, pwm_out=0.

Source files
------------

// File: rtl/vcxo_loop_filter.sv
// VCXO loop filter: PFD up/down pulses drive a clamped PI integrator, a 16-bit PWM DAC
// and a windowed lock detector. Everything runs on the reference clock.
module vcxo_loop_filter #(
  parameter int KI         = 1,
  parameter int KP         = 256,
  parameter int WIN        = 48000,
  parameter int LOCK_THR   = 48,
  parameter int UNLOCK_THR = 480,
  parameter int LOCK_CNT   = 8
) (
  input  logic        ref_in,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        up,
  input  logic        down,
  output logic [15:0] tune,
  output logic        pwm_out,
  output logic        locked,
  output logic        saturated
);
  localparam int AW = $clog2(WIN + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [24:0]        KI_W    = 25'(KI);
  localparam logic [24:0]        ACC_MAX = 25'h0FF_FFFF;
  localparam logic signed [17:0] KP_S    = 18'(KP);
  localparam logic [31:0]        LOCK_T  = 32'(LOCK_THR);
  localparam logic [31:0]        UNLK_T  = 32'(UNLOCK_THR);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t          state;
  logic [1:0]      up_sync, dn_sync;
  logic            up_s, dn_s, inc, dec, run;
  logic [23:0]     acc, acc_nxt;
  logic [24:0]     acc_inc;
  logic            inc_d, dec_d, run_d;
  logic signed [17:0] kp_off, tune_sum;
  logic [15:0]     tune_nxt, duty, pwm_cnt;
  logic [AW-1:0]   win_cnt, act_cnt, act_tot;
  logic [GW-1:0]   good_cnt;
  logic            win_end;

  always_ff @(posedge ref_in) begin
    if (!rst_n) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], up};
      dn_sync <= {dn_sync[0], down};
    end
  end

  assign up_s = up_sync[1];
  assign dn_s = dn_sync[1];
  assign inc  = up_s & ~dn_s;
  assign dec  = dn_s & ~up_s;
  assign run  = (state != IDLE) && enable;

  // Integrator: saturating step, never wraps.
  assign acc_inc = {1'b0, acc} + KI_W;
  always_comb begin
    acc_nxt = acc;
    if (run && inc)
      acc_nxt = (acc_inc > ACC_MAX) ? 24'hFF_FFFF : acc_inc[23:0];
    else if (run && dec)
      acc_nxt = ({1'b0, acc} < KI_W) ? 24'h00_0000 : acc - KI_W[23:0];
  end

  assign saturated = (acc == 24'h00_0000) || (acc == 24'hFF_FFFF);

  // Proportional term follows the integrator by one cycle so tune sees the updated acc.
  always_comb begin
    kp_off = 18'sd0;
    if (inc_d)      kp_off = KP_S;
    else if (dec_d) kp_off = -KP_S;
    tune_sum = $signed({2'b00, acc[23:8]}) + kp_off;
    if (tune_sum[17])      tune_nxt = 16'h0000;
    else if (tune_sum[16]) tune_nxt = 16'hFFFF;
    else                   tune_nxt = tune_sum[15:0];
  end

  always_ff @(posedge ref_in) begin
    if (!rst_n) begin
      acc   <= 24'h80_0000;
      tune  <= 16'h8000;
      inc_d <= 1'b0;
      dec_d <= 1'b0;
      run_d <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      inc_d <= run & inc;
      dec_d <= run & dec;
      run_d <= run;
      if (run_d) tune <= tune_nxt;
    end
  end

  // PWM DAC; duty is only reloaded at the period boundary.
  always_ff @(posedge ref_in) begin
    if (!rst_n) begin
      pwm_cnt <= 16'h0000;
      duty    <= 16'h8000;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 16'd1;
      pwm_out <= (pwm_cnt < duty);
      if (pwm_cnt == 16'hFFFF) duty <= tune;
    end
  end

  // Lock detector: active cycles per window include the evaluation cycle itself.
  assign act_tot = act_cnt + AW'(up_s | dn_s);
  assign win_end = (win_cnt == AW'(WIN - 1));

  always_ff @(posedge ref_in) begin
    if (!rst_n) begin
      state    <= IDLE;
      win_cnt  <= '0;
      act_cnt  <= '0;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (!enable) begin
      state  <= IDLE;
      locked <= 1'b0;
    end else if (state == IDLE) begin
      state    <= ACQUIRE;
      win_cnt  <= '0;
      act_cnt  <= '0;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (!win_end) begin
      win_cnt <= win_cnt + 1'b1;
      act_cnt <= act_tot;
    end else begin
      win_cnt <= '0;
      act_cnt <= '0;
      if (state == ACQUIRE) begin
        if (32'(act_tot) <= LOCK_T) begin
          if (good_cnt == GW'(LOCK_CNT - 1)) begin
            state    <= LOCKED;
            locked   <= 1'b1;
            good_cnt <= '0;
          end else begin
            good_cnt <= good_cnt + 1'b1;
          end
        end else begin
          good_cnt <= '0;
        end
      end else if (32'(act_tot) >= UNLK_T) begin
        state    <= ACQUIRE;
        locked   <= 1'b0;
        good_cnt <= '0;
      end
    end
  end
endmodule
